// File: rtl/ibex_ipm_gf_unit_pkg.sv
// ibex_ipm_gf_unit_pkg: operator/state encodings and the GF(2^8) xtime helper
// shared by the IPM GF unit and its lane datapath.
package ibex_ipm_gf_unit_pkg;

    localparam logic [7:0] IPM_GF_POLY_AES = 8'h1B;

    typedef enum logic [2:0] {
        IPM_MUL   = 3'd0,
        IPM_SQR   = 3'd1,
        IPM_LMUL  = 3'd2,
        IPM_INNER = 3'd3,
        IPM_SETL  = 3'd4
    } ipm_op_e;

    typedef enum logic [1:0] {
        IPM_IDLE = 2'd0,
        IPM_CALC = 2'd1,
        IPM_DONE = 2'd2
    } ipm_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] v, input logic [7:0] poly);
        return {v[6:0], 1'b0} ^ (v[7] ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/ibex_ipm_gf_unit_if.sv
// ibex_ipm_gf_unit_if: request/result bus between the EX stage and the IPM GF unit.
interface ibex_ipm_gf_unit_if;
    logic [2:0]  ipm_operator_i;
    logic        ipm_en_i;
    logic        ipm_sel_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        ipm_ready_id_i;
    logic [31:0] result_o;
    logic        valid_o;
    logic        busy_o;

    modport master (
        output ipm_operator_i, ipm_en_i, ipm_sel_i, a_i, b_i, ipm_ready_id_i,
        input  result_o, valid_o, busy_o
    );

    modport slave (
        input  ipm_operator_i, ipm_en_i, ipm_sel_i, a_i, b_i, ipm_ready_id_i,
        output result_o, valid_o, busy_o
    );
endinterface

// File: rtl/ibex_ipm_gf_unit_lane.sv
// ibex_ipm_gf_unit_lane: Bits MSB-first Horner steps of a GF(2^8) multiply on one byte lane.
module ibex_ipm_gf_unit_lane
    import ibex_ipm_gf_unit_pkg::*;
#(
    parameter int unsigned Bits = 2
) (
    input  logic [7:0]      acc_i,
    input  logic [7:0]      a_i,
    input  logic [Bits-1:0] m_i,
    input  logic [7:0]      poly_i,
    output logic [7:0]      acc_o
);
    logic [Bits-1:0] m;

    always_comb begin
        acc_o = acc_i;
        m = m_i;
        for (int k = 0; k < Bits; k++) begin
            acc_o = xtime(acc_o, poly_i) ^ (m[Bits-1] ? a_i : 8'h00);
            m = m << 1;
        end
    end
endmodule

// File: rtl/ibex_ipm_gf_unit.sv
// ibex_ipm_gf_unit: multi-cycle GF(2^8) inner-product-masking coprocessor with 4 byte lanes,
// data-independent latency of 8/BitsPerCycle CALC cycles.
module ibex_ipm_gf_unit
    import ibex_ipm_gf_unit_pkg::*;
#(
    parameter logic [7:0]  GfPoly       = IPM_GF_POLY_AES,
    parameter int unsigned BitsPerCycle = 2,
    parameter logic [31:0] ResetL       = 32'h01010101
) (
    input logic               clk_i,
    input logic               rst_i,
    ibex_ipm_gf_unit_if.slave bus
);
    localparam int unsigned B = BitsPerCycle;
    localparam int unsigned N = 8 / BitsPerCycle;

    if (!(B == 1 || B == 2 || B == 4 || B == 8)) begin : g_bad_bpc
        $error("BitsPerCycle must be 1, 2, 4 or 8");
    end

    ipm_state_e  state_q;
    logic [2:0]  cnt_q;
    logic [31:0] a_q, m_q, acc_q, l_q;
    logic [31:0] acc_d, m_d, m_sel;
    logic        inner_q, start, setl;
    logic [7:0]  inner_res;

    assign start = state_q == IPM_IDLE && bus.ipm_en_i && bus.ipm_sel_i;
    assign setl  = start && bus.ipm_operator_i == IPM_SETL;
    assign m_sel = bus.ipm_operator_i == IPM_SQR  ? bus.a_i :
                   bus.ipm_operator_i == IPM_LMUL ? l_q : bus.b_i;

    // each lane consumes the top B bits of its multiplier byte, which then shifts left
    for (genvar i = 0; i < 4; i++) begin : g_lane
        ibex_ipm_gf_unit_lane #(.Bits(B)) u_lane (
            .acc_i  (acc_q[8*i +: 8]),
            .a_i    (a_q[8*i +: 8]),
            .m_i    (m_q[8*i+7 -: B]),
            .poly_i (GfPoly),
            .acc_o  (acc_d[8*i +: 8])
        );
        assign m_d[8*i +: 8] = m_q[8*i +: 8] << B;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IPM_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            inner_q <= 1'b0;
            l_q     <= ResetL;
        end else begin
            case (state_q)
                IPM_IDLE: begin
                    if (setl) begin
                        l_q <= bus.a_i;
                    end else if (start) begin
                        a_q     <= bus.a_i;
                        m_q     <= m_sel;
                        inner_q <= bus.ipm_operator_i == IPM_INNER;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= IPM_CALC;
                    end
                end
                IPM_CALC: begin
                    if (!bus.ipm_en_i) begin
                        acc_q   <= '0;
                        state_q <= IPM_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        m_q   <= m_d;
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q == 3'(N - 1)) state_q <= IPM_DONE;
                    end
                end
                IPM_DONE: begin
                    if (!bus.ipm_en_i) begin
                        acc_q   <= '0;
                        state_q <= IPM_IDLE;
                    end else if (bus.ipm_ready_id_i) begin
                        state_q <= IPM_IDLE;
                    end
                end
                default: state_q <= IPM_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (start) assert (bus.ipm_operator_i <= IPM_SETL);
    end

    assign inner_res    = acc_q[31:24] ^ acc_q[23:16] ^ acc_q[15:8] ^ acc_q[7:0];
    assign bus.valid_o  = state_q == IPM_DONE || setl;
    assign bus.busy_o   = state_q != IPM_IDLE;
    assign bus.result_o = state_q != IPM_DONE ? 32'h0 : inner_q ? {24'h0, inner_res} : acc_q;
endmodule
